// File: rtl/palette_pkg.sv
// palette_pkg: types shared by the palette lookup block.
//   CHAN_W_DEF   default bits per colour channel
//   rgb_t        packed {r,g,b} colour word at the default channel width
//   swap_state_e states of the active-bank swap controller
package palette_pkg;

    localparam int CHAN_W_DEF = 4;

    typedef struct packed {
        logic [CHAN_W_DEF-1:0] r;
        logic [CHAN_W_DEF-1:0] g;
        logic [CHAN_W_DEF-1:0] b;
    } rgb_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_e;

endpackage

// File: rtl/palette_bank_ram.sv
// palette_bank_ram: simple dual-port palette storage, one write port and one
// registered read port. All banks live in one array, addressed as {bank, index}.
//   clk    clock
//   we     write strobe (caller has already range-checked the bank)
//   waddr  {bank, index} written
//   wdata  {R,G,B} written
//   re     read enable; rdata holds its value while re=0
//   raddr  {bank, index} read
//   rdata  registered read data (read-before-write on an address collision)
module palette_bank_ram #(
    parameter int INDEX_W   = 8,
    parameter int CHAN_W    = 4,
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 1
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [BANK_W+INDEX_W-1:0]   waddr,
    input  logic [3*CHAN_W-1:0]         wdata,
    input  logic                        re,
    input  logic [BANK_W+INDEX_W-1:0]   raddr,
    output logic [3*CHAN_W-1:0]         rdata
);

    localparam int DEPTH = NUM_BANKS << INDEX_W;

    logic [3*CHAN_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/palette_lut_banked.sv
// palette_lut_banked: runtime-writable multi-bank colour palette lookup with a
// two-register pipeline and a frame-synchronous active-bank swap.
//   clk, resetn              clock, synchronous active-low reset
//   px_valid, px_index       lookup request
//   frame_start              one-cycle pulse at start of vertical blank
//   swap_req, swap_bank      request a new active bank at the next frame_start
//   wr_en, wr_bank, wr_addr, wr_data   palette write port
//   out_valid                px_valid delayed two cycles
//   red, green, blue         looked-up colour, held while out_valid=0
//   out_transp               looked-up index was the transparent index
//   active_bank              bank used for new lookups
//   swap_pending             a swap is latched and waiting for frame_start
module palette_lut_banked
    import palette_pkg::*;
#(
    parameter int INDEX_W    = 8,
    parameter int CHAN_W     = CHAN_W_DEF,
    parameter int NUM_BANKS  = 2,
    parameter int TRANSP_IDX = 0,
    parameter int TRANSP_EN  = 1,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  px_valid,
    input  logic [INDEX_W-1:0]    px_index,
    input  logic                  frame_start,
    input  logic                  swap_req,
    input  logic [BANK_W-1:0]     swap_bank,
    input  logic                  wr_en,
    input  logic [BANK_W-1:0]     wr_bank,
    input  logic [INDEX_W-1:0]    wr_addr,
    input  logic [3*CHAN_W-1:0]   wr_data,
    output logic                  out_valid,
    output logic [CHAN_W-1:0]     red,
    output logic [CHAN_W-1:0]     green,
    output logic [CHAN_W-1:0]     blue,
    output logic                  out_transp,
    output logic [BANK_W-1:0]     active_bank,
    output logic                  swap_pending
);

    localparam int                 RGB_W = 3 * CHAN_W;
    localparam logic [BANK_W:0]    NB    = NUM_BANKS[BANK_W:0];
    localparam logic [INDEX_W-1:0] TIDX  = TRANSP_IDX[INDEX_W-1:0];
    localparam logic               TEN   = (TRANSP_EN != 0);

    // Out-of-range bank numbers are dropped before they reach state or RAM.
    logic swap_ok;
    logic wr_ok;
    assign swap_ok = swap_req && ({1'b0, swap_bank} < NB);
    assign wr_ok   = wr_en && ({1'b0, wr_bank} < NB);

    swap_state_e         state_q, state_d;
    logic [BANK_W-1:0]   pend_bank_q, pend_bank_d;
    logic [BANK_W-1:0]   act_bank_q, act_bank_d;

    // A request coinciding with frame_start applies immediately and never
    // shows as pending; a later request while pending replaces the bank.
    always_comb begin
        state_d     = state_q;
        pend_bank_d = pend_bank_q;
        act_bank_d  = act_bank_q;
        if (swap_ok && frame_start) begin
            act_bank_d = swap_bank;
            state_d    = IDLE;
        end else if (swap_ok) begin
            pend_bank_d = swap_bank;
            state_d     = PENDING;
        end else if (frame_start && (state_q == PENDING)) begin
            act_bank_d = pend_bank_q;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            pend_bank_q <= '0;
            act_bank_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_bank_q <= pend_bank_d;
            act_bank_q  <= act_bank_d;
        end
    end

    assign active_bank  = act_bank_q;
    assign swap_pending = (state_q == PENDING);

    // ---- stage 1: capture request with the bank active at request time ----
    logic                vld_p1;
    logic [INDEX_W-1:0]  idx_p1;
    logic [BANK_W-1:0]   bank_p1;
    logic                transp_p1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= px_valid;
        end
    end

    always_ff @(posedge clk) begin
        idx_p1    <= px_index;
        bank_p1   <= act_bank_q;
        transp_p1 <= (px_index == TIDX);
    end

    // ---- stage 2: RAM read, write-first bypass, colour hold ----
    logic              hit_p1;
    logic [RGB_W-1:0]  ram_q_p2;
    logic              vld_p2;
    logic              clr_p2;
    logic              byp_p2;
    logic [RGB_W-1:0]  byp_data_p2;
    logic              transp_p2;
    logic [RGB_W-1:0]  col_p2;

    assign hit_p1 = wr_ok && (wr_bank == bank_p1) && (wr_addr == idx_p1);

    palette_bank_ram #(
        .INDEX_W   (INDEX_W),
        .CHAN_W    (CHAN_W),
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr ({wr_bank, wr_addr}),
        .wdata (wr_data),
        .re    (vld_p1),
        .raddr ({bank_p1, idx_p1}),
        .rdata (ram_q_p2)
    );

    // clr_p2 forces the colour to zero after reset without resetting the RAM
    // output register; it drops at the first real lookup.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p2 <= 1'b0;
            clr_p2 <= 1'b1;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                clr_p2 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            byp_p2      <= hit_p1;
            byp_data_p2 <= wr_data;
            transp_p2   <= transp_p1;
        end
    end

    always_comb begin
        col_p2 = ram_q_p2;
        if (clr_p2) begin
            col_p2 = '0;
        end else if (byp_p2) begin
            col_p2 = byp_data_p2;
        end
    end

    assign out_valid  = vld_p2;
    assign red        = col_p2[RGB_W-1 -: CHAN_W];
    assign green      = col_p2[2*CHAN_W-1 -: CHAN_W];
    assign blue       = col_p2[CHAN_W-1:0];
    assign out_transp = TEN && vld_p2 && transp_p2;

endmodule

// File: tb/tb_palette_lut_banked.sv
module tb_palette_lut_banked;
    import palette_pkg::*;

    localparam int INDEX_W   = 8;
    localparam int CHAN_W    = 4;
    localparam int NUM_BANKS = 2;
    localparam int DEPTH     = 1 << INDEX_W;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 px_valid;
    logic [INDEX_W-1:0]   px_index;
    logic                 frame_start;
    logic                 swap_req;
    logic [0:0]           swap_bank;
    logic                 wr_en;
    logic [0:0]           wr_bank;
    logic [INDEX_W-1:0]   wr_addr;
    logic [3*CHAN_W-1:0]  wr_data;

    logic                 out_valid, out_transp, swap_pending;
    logic [CHAN_W-1:0]    red, green, blue;
    logic [0:0]           active_bank;

    logic                 out_valid2, out_transp2, swap_pending2;
    logic [CHAN_W-1:0]    red2, green2, blue2;
    logic [0:0]           active_bank2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    palette_lut_banked u_dut (
        .clk(clk), .resetn(resetn), .px_valid(px_valid), .px_index(px_index),
        .frame_start(frame_start), .swap_req(swap_req), .swap_bank(swap_bank),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .red(red), .green(green), .blue(blue),
        .out_transp(out_transp), .active_bank(active_bank), .swap_pending(swap_pending)
    );

    palette_lut_banked #(.TRANSP_EN(0)) u_dut_nt (
        .clk(clk), .resetn(resetn), .px_valid(px_valid), .px_index(px_index),
        .frame_start(frame_start), .swap_req(swap_req), .swap_bank(swap_bank),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid2), .red(red2), .green(green2), .blue(blue2),
        .out_transp(out_transp2), .active_bank(active_bank2), .swap_pending(swap_pending2)
    );

    // Reference model: palette contents, active/pending bank, and the one
    // lookup that is in flight between request and result.
    rgb_t m_mem [NUM_BANKS][DEPTH];
    int   m_act, m_pend, m_pbank;
    int   s1_v, s1_bank, s1_idx;
    int   e_valid, e_transp;
    rgb_t e_col;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_in();
        px_valid    = 1'b0;
        px_index    = '0;
        frame_start = 1'b0;
        swap_req    = 1'b0;
        swap_bank   = '0;
        wr_en       = 1'b0;
        wr_bank     = '0;
        wr_addr     = '0;
        wr_data     = '0;
    endtask

    // One clock: update the model from the inputs seen at this edge, then
    // compare every output half a cycle later.
    task automatic step();
        @(posedge clk);
        if (wr_en) m_mem[wr_bank][wr_addr] = rgb_t'(wr_data);
        if (!resetn) begin
            m_act = 0; m_pend = 0; m_pbank = 0;
            s1_v = 0; e_valid = 0; e_transp = 0; e_col = '0;
        end else begin
            e_valid  = s1_v;
            e_transp = (s1_v != 0 && s1_idx == 0) ? 1 : 0;
            if (s1_v != 0) e_col = m_mem[s1_bank][s1_idx];
            s1_v    = px_valid ? 1 : 0;
            s1_bank = m_act;
            s1_idx  = int'(px_index);
            if (swap_req && frame_start) begin
                m_act  = int'(swap_bank);
                m_pend = 0;
            end else if (swap_req) begin
                m_pend  = 1;
                m_pbank = int'(swap_bank);
            end else if (frame_start && m_pend != 0) begin
                m_act  = m_pbank;
                m_pend = 0;
            end
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("colour", 32'({red, green, blue}), 32'(e_col));
        chk("out_transp", 32'(out_transp), 32'(e_transp));
        chk("active_bank", 32'(active_bank), 32'(m_act));
        chk("swap_pending", 32'(swap_pending), 32'(m_pend));
        chk("transp_disabled", 32'(out_transp2), 32'd0);
    endtask

    task automatic wr(input int b, input int a, input logic [11:0] d);
        wr_en = 1'b1; wr_bank = 1'(b); wr_addr = 8'(a); wr_data = d;
    endtask

    task automatic req(input int idx);
        px_valid = 1'b1; px_index = 8'(idx);
    endtask

    initial begin
        idle_in();
        resetn = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_colour", 32'({red, green, blue}), 32'd0);
        resetn = 1'b1;

        // Fill every entry so later lookups are well defined.
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                wr(b, a, 12'($urandom));
                step();
            end
        end
        idle_in();

        // Basic lookup.
        wr(0, 5, 12'hA3C); step(); idle_in();
        req(5); step(); idle_in(); step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_colour", 32'({red, green, blue}), 32'hA3C);
        chk("t1_transp", 32'(out_transp), 32'd0);
        step();
        chk("t1_hold", 32'({red, green, blue}), 32'hA3C);

        // Write-first bypass.
        req(7); step(); idle_in();
        wr(0, 7, 12'hFFF); step(); idle_in();
        chk("t4_bypass", 32'({red, green, blue}), 32'hFFF);

        // Transparent index.
        req(0); step(); idle_in(); step();
        chk("t5_transp", 32'(out_transp), 32'd1);
        chk("t5_transp_off", 32'(out_transp2), 32'd0);

        // Deferred swap.
        wr(1, 5, 12'h123); step(); idle_in();
        swap_req = 1'b1; swap_bank = 1'b1; step(); idle_in();
        chk("t2_pending", 32'(swap_pending), 32'd1);
        req(5); step(); idle_in(); step();
        chk("t2_old_bank", 32'({red, green, blue}), 32'hA3C);
        frame_start = 1'b1; step(); idle_in();
        chk("t2_active", 32'(active_bank), 32'd1);
        chk("t2_cleared", 32'(swap_pending), 32'd0);
        req(5); step(); idle_in(); step();
        chk("t2_new_bank", 32'({red, green, blue}), 32'h123);

        // Immediate swap when request and frame_start coincide.
        swap_req = 1'b1; swap_bank = 1'b0; frame_start = 1'b1; step(); idle_in();
        chk("t3_back0", 32'(active_bank), 32'd0);
        swap_req = 1'b1; swap_bank = 1'b1; frame_start = 1'b1; step(); idle_in();
        chk("t3_active", 32'(active_bank), 32'd1);
        chk("t3_no_pending", 32'(swap_pending), 32'd0);
        frame_start = 1'b1; step(); idle_in();
        chk("t3_fs_noop", 32'(active_bank), 32'd1);

        // Reset mid-stream; palette contents survive.
        req(1); step();
        req(2); resetn = 1'b0; step();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_bank", 32'(active_bank), 32'd0);
        resetn = 1'b1;
        req(3); step();
        req(4); step(); idle_in();
        req(5); step(); idle_in(); step();
        chk("t6_preserved", 32'({red, green, blue}), 32'hA3C);

        // Randomised traffic, biased to small indices to hit collisions.
        for (int i = 0; i < 1500; i++) begin
            idle_in();
            px_valid    = ($urandom_range(0, 3) != 0);
            px_index    = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            wr_en       = ($urandom_range(0, 2) == 0);
            wr_bank     = 1'($urandom);
            wr_addr     = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            wr_data     = 12'($urandom);
            swap_req    = ($urandom_range(0, 9) == 0);
            swap_bank   = 1'($urandom);
            frame_start = ($urandom_range(0, 11) == 0);
            resetn      = ($urandom_range(0, 99) != 0);
            step();
        end
        idle_in();
        resetn = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
